// File: rtl/div8su4_seq.sv
// div8su4_seq: sequential signed-8 / unsigned-4 restoring divider, truncating toward zero.
module div8su4_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] s,
  input  logic [3:0] u,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] q,
  output logic [4:0] r,
  output logic       dbz
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t     state_q;
  logic [7:0] a_q;
  logic [3:0] rem_q, u_q;
  logic       neg_q;
  logic [2:0] cnt_q;
  logic [4:0] sh_d, sub_d;
  logic       ge_d;
  always_comb begin
    sh_d  = {rem_q, a_q[7]};
    ge_d  = sh_d >= {1'b0, u_q};
    sub_d = ge_d ? sh_d - {1'b0, u_q} : sh_d;
  end
  // a_q holds |s| and collects quotient bits from the LSB as dividend bits leave the MSB
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      q         <= '0;
      r         <= '0;
      dbz       <= 1'b0;
      a_q       <= '0;
      rem_q     <= '0;
      u_q       <= '0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid && in_ready) begin
          in_ready <= 1'b0;
          neg_q    <= s[7];
          a_q      <= s[7] ? -s : s;
          u_q      <= u;
          rem_q    <= '0;
          cnt_q    <= '0;
          dbz      <= u == 4'd0;
          state_q  <= (u == 4'd0) ? FIX : CALC;
        end
        CALC: begin
          rem_q <= sub_d[3:0];
          a_q   <= {a_q[6:0], ge_d};
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_q <= FIX;
        end
        FIX: begin
          q         <= dbz ? (neg_q ? 8'h80 : 8'h7F) : (neg_q ? -a_q : a_q);
          r         <= dbz ? 5'd0 : (neg_q ? -{1'b0, rem_q} : {1'b0, rem_q});
          out_valid <= 1'b1;
          state_q   <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div8su4_seq.sv
// tb_div8su4_seq: directed and exhaustive checks of div8su4_seq against a truncating-division model.
module tb_div8su4_seq;
  logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] s = '0;
  logic [3:0] u = '0;
  logic       in_ready, out_valid, dbz;
  logic [7:0] q;
  logic [4:0] r;
  int checks = 0, failures = 0;

  div8su4_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .s(s), .u(u),
    .out_valid(out_valid), .out_ready(out_ready), .q(q), .r(r), .dbz(dbz)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [7:0] sv, input logic [3:0] uv);
    int n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    if (n == 40) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    s = sv;
    u = uv;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic op(input logic [7:0] sv, input logic [3:0] uv, input int hold);
    int si, ui, qi, ri, lat;
    logic [7:0] eq;
    logic [4:0] er;
    si = $signed(sv);
    ui = uv;
    if (ui == 0) begin
      eq = sv[7] ? 8'h80 : 8'h7F;
      er = '0;
    end else begin
      qi = si / ui;
      ri = si % ui;
      eq = qi[7:0];
      er = ri[4:0];
    end
    start(sv, uv);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk($sformatf("lat s=%0d u=%0d", si, ui), lat, (ui == 0) ? 1 : 9);
    chk($sformatf("q s=%0d u=%0d", si, ui), 32'(q), 32'(eq));
    chk($sformatf("r s=%0d u=%0d", si, ui), 32'(r), 32'(er));
    chk($sformatf("dbz s=%0d u=%0d", si, ui), 32'(dbz), 32'(ui == 0));
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      s = 8'($urandom);
      u = 4'($urandom);
      tick();
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_q", 32'(q), 32'(eq));
      chk("hold_r", 32'(r), 32'(er));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_out_valid", 32'(out_valid), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_r", 32'(r), 32'd0);
    chk("rst_dbz", 32'(dbz), 32'd0);
    op(8'd100, 4'd7, 0);
    op(8'h9C, 4'd7, 0);
    op(8'h80, 4'd1, 0);
    op(8'h7F, 4'd1, 0);
    op(8'd5, 4'd0, 0);
    op(8'hFB, 4'd0, 0);
    op(8'd9, 4'd3, 0);
    op(8'd100, 4'd7, 20);
    start(8'd50, 4'd3);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_q", 32'(q), 32'd0);
    chk("midrst_r", 32'(r), 32'd0);
    repeat (12) begin
      tick();
      chk("midrst_no_valid", 32'(out_valid), 32'd0);
    end
    op(8'd15, 4'd4, 0);
    for (int a = 0; a < 256; a++)
      for (int b = 0; b < 16; b++)
        op(a[7:0], b[3:0], $urandom_range(0, 2));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/div8su4_seq.md
DIV8SU4_SEQ -- requirements
Module: div8su4_seq

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is synchronous and active-high.
REQ-002 The block SHALL have the following ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block can accept operands.
- s  in  8  signed dividend, two's complement.
- u  in  4  unsigned divisor.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- q  out  8  signed quotient, two's complement.
- r  out  5  signed remainder, two's complement.
- dbz  out  1  divide-by-zero flag, qualified by out_valid.
REQ-003 The block SHALL have no parameters; all widths are fixed.

Function
REQ-004 The block SHALL compute s / u with the quotient truncated toward zero, so that s = q*u + r, |r| < u, and r is zero or has the sign of s.
REQ-005 The block SHALL run a four-state FSM: IDLE, CALC, FIX, DONE.
REQ-006 The block SHALL assert in_ready only in IDLE; an accept is in_valid & in_ready at a rising edge.
REQ-007 On an accept with u != 0, the block SHALL:
- latch |s| as an 8-bit unsigned value (|-128| = 128), u, and sign(s);
- clear the 4-bit partial remainder and the iteration counter;
- enter CALC.
REQ-008 In CALC, the block SHALL perform one restoring-division step per cycle, MSB of |s| first:
- shift the next dividend bit into the partial remainder (5 bits wide);
- subtract u when the remainder is >= u, and shift the result bit into the quotient.
REQ-009 The block SHALL spend exactly 8 cycles in CALC, then 1 cycle in FIX.
REQ-010 In FIX, the block SHALL negate the quotient and remainder when s < 0, register q and r, and enter DONE.
REQ-011 out_valid SHALL rise 9 edges after the accept edge, i.e. after the edge that enters DONE.
REQ-012 On an accept with u == 0, the block SHALL go directly to DONE on the next edge with:
- dbz=1;
- q=8'h7F if s >= 0, else 8'h80;
- r=0.
REQ-013 In DONE, the block SHALL hold out_valid=1; q, r and dbz SHALL stay stable until out_valid & out_ready.
REQ-014 On out_valid & out_ready, the block SHALL:
- return to IDLE on that edge;
- deassert out_valid;
- assert in_ready in the next cycle.
There is no same-cycle accept in DONE.
REQ-015 While not in IDLE, the block SHALL ignore in_valid, s and u; operands are sampled only on the accept edge.
REQ-016 The block SHALL clear dbz on every accept with u != 0.
REQ-017 The block SHALL never overflow: -128/1 gives q=8'h80, r=0, and 127/1 gives q=8'h7F, r=0.
REQ-018 Outputs SHALL change only on rising clk edges; no combinational path from in_valid or out_ready to any output.

Reset
REQ-019 When rst=1 at a rising edge, the block SHALL:
- force state to IDLE;
- clear q, r, dbz, out_valid, the counter and the datapath registers;
- assert in_ready in the following cycle.
REQ-020 rst SHALL override every other input, including a simultaneous accept or out_ready.
REQ-021 A reset received in CALC, FIX or DONE SHALL discard the operation in flight; no out_valid is produced for it.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- s=100, u=7 -> out_valid 9 edges after accept, q=8'h0E (14), r=5'h02, dbz=0.
- s=-100 (8'h9C), u=7 -> q=8'hF2 (-14), r=5'h1E (-2); s=-128, u=1 -> q=8'h80, r=0.
- s=5, u=0 -> out_valid 1 edge after accept, dbz=1, q=8'h7F, r=0; s=-5, u=0 -> q=8'h80. Then s=9, u=3 -> dbz=0, q=3.
- out_ready held 0 for 20 cycles in DONE -> out_valid, q, r constant, in_ready=0, and new in_valid pulses ignored; out_ready=1 -> IDLE the next cycle.
- rst asserted in the 4th CALC cycle -> next cycle in_ready=1, out_valid=0, q=r=0; a following s=15, u=4 gives q=3, r=3.
REQ-023 The bench SHALL check all 256x16 operand pairs against a reference truncating-division model, with random out_ready backpressure.
